// File: rtl/mc_datapath_pkg.sv
// Shared CPU definitions: ALU operation encodings and base opcodes.
package mc_datapath_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluSra  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcLui   = 7'b0110111;

  localparam int unsigned XLen    = 32;
  localparam int unsigned NumRegs = 32;

endpackage

// File: rtl/mc_datapath_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 is hard-wired to zero on read and never written.
module reg_file
  import mc_datapath_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLen-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  output logic [XLen-1:0] rdata1_o,
  input  logic [4:0]      raddr2_i,
  output logic [XLen-1:0] rdata2_o
);

  logic [XLen-1:0] mem_q [NumRegs];

  // Storage update: reset clears every entry, writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous reads; same-cycle writes are not bypassed.
  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? '0 : mem_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? '0 : mem_q[raddr2_i];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32 datapath: PC/IR fetch, register file, A/B operand latches,
// inline ALU with flag generation, and F/flag result registers.
module mc_datapath
  import mc_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ALU_OP,
  input  logic        rs2_imm_s,
  input  logic        w_data_s,
  input  logic        Reg_Write,
  input  logic        IR_Write,
  input  logic        PC_Write,
  input  logic [31:0] inst_data,
  output logic [31:0] inst_addr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] alu_f,
  output logic [3:0]  flags
);

  logic [31:0] pc_q, ir_q, a_q, b_q, f_q;
  logic [3:0]  flags_q;

  logic [31:0] rs1_data, rs2_data, w_data;
  logic [31:0] imm_i, imm_u, alu_b, alu_res;
  logic [32:0] sum_ext, diff_ext;
  logic [4:0]  shamt;
  logic        alu_cf, alu_of;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {ir_q[31:12], 12'b0};
  // rd and imm_u come from the current IR, so a concurrent fetch cannot redirect write-back.
  assign w_data = w_data_s ? imm_u : f_q;

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we_i     (Reg_Write),
    .waddr_i  (ir_q[11:7]),
    .wdata_i  (w_data),
    .raddr1_i (ir_q[19:15]),
    .rdata1_o (rs1_data),
    .raddr2_i (ir_q[24:20]),
    .rdata2_o (rs2_data)
  );

  assign alu_b    = rs2_imm_s ? imm_i : b_q;
  assign shamt    = alu_b[4:0];
  assign sum_ext  = {1'b0, a_q} + {1'b0, alu_b};
  assign diff_ext = {1'b0, a_q} - {1'b0, alu_b};

  // ALU result with carry/borrow and signed overflow for ADD/SUB only.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    unique case (alu_op_e'(ALU_OP))
      AluAdd: begin
        alu_res = sum_ext[31:0];
        alu_cf  = sum_ext[32];
        alu_of  = (a_q[31] == alu_b[31]) && (alu_res[31] != a_q[31]);
      end
      AluSub: begin
        alu_res = diff_ext[31:0];
        alu_cf  = diff_ext[32];
        alu_of  = (a_q[31] != alu_b[31]) && (alu_res[31] != a_q[31]);
      end
      AluSll:  alu_res = a_q << shamt;
      AluSrl:  alu_res = a_q >> shamt;
      AluSra:  alu_res = $unsigned($signed(a_q) >>> shamt);
      AluSlt:  alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
      AluSltu: alu_res = {31'b0, a_q < alu_b};
      AluXor:  alu_res = a_q ^ alu_b;
      AluOr:   alu_res = a_q | alu_b;
      AluAnd:  alu_res = a_q & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Architectural state: fetch registers, operand latches and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      flags_q <= '0;
    end else begin
      if (PC_Write) pc_q <= pc_q + 32'd4;
      if (IR_Write) ir_q <= inst_data;
      a_q     <= rs1_data;
      b_q     <= rs2_data;
      f_q     <= alu_res;
      flags_q <= {alu_res == 32'd0, alu_res[31], alu_cf, alu_of};
    end
  end

  assign inst_addr = pc_q;
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign alu_f     = f_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed scenarios plus randomized
// control/instruction streams compared against a behavioural model.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ALU_OP;
  logic        rs2_imm_s, w_data_s, Reg_Write, IR_Write, PC_Write;
  logic [31:0] inst_data;
  logic [31:0] inst_addr, alu_f;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [3:0]  flags;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model state.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ir, m_a, m_b, m_f;
  logic [3:0]  m_flags;

  mc_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .ALU_OP    (ALU_OP),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .Reg_Write (Reg_Write),
    .IR_Write  (IR_Write),
    .PC_Write  (PC_Write),
    .inst_data (inst_data),
    .inst_addr (inst_addr),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_f     (alu_f),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference ALU from arithmetic definitions (wide integers for carry/overflow).
  task automatic model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [3:0] fl);
    longint unsigned u;
    longint          s;
    logic            cf, of;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      4'b0000: begin
        u   = longint'({32'b0, a}) + longint'({32'b0, b});
        res = u[31:0];
        cf  = (u > 64'h0000_0000_FFFF_FFFF);
        s   = longint'($signed(a)) + longint'($signed(b));
        of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1000: begin
        res = a - b;
        cf  = (a < b);
        s   = longint'($signed(a)) - longint'($signed(b));
        of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: res = a << b[4:0];
      4'b0101: res = a >> b[4:0];
      4'b1101: res = $unsigned($signed(a) >>> b[4:0]);
      4'b0010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: res = (a < b) ? 32'd1 : 32'd0;
      4'b0100: res = a ^ b;
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      default: res = 32'd0;
    endcase
    fl = {res == 32'd0, res[31], cf, of};
  endtask

  // One clock of architectural behaviour, all next values taken from pre-edge state.
  task automatic model_step();
    logic [31:0] res, bsel, na, nb;
    logic [3:0]  fl;
    logic [4:0]  rs1, rs2, rd;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_f = 0; m_flags = 0;
    end else begin
      rs1  = m_ir[19:15];
      rs2  = m_ir[24:20];
      rd   = m_ir[11:7];
      bsel = rs2_imm_s ? {{20{m_ir[31]}}, m_ir[31:20]} : m_b;
      model_alu(ALU_OP, m_a, bsel, res, fl);
      na = (rs1 == 0) ? 32'd0 : m_regs[rs1];
      nb = (rs2 == 0) ? 32'd0 : m_regs[rs2];
      if (Reg_Write && rd != 0) m_regs[rd] = w_data_s ? {m_ir[31:12], 12'h000} : m_f;
      if (IR_Write) m_ir = inst_data;
      if (PC_Write) m_pc = m_pc + 32'd4;
      m_a = na; m_b = nb; m_f = res; m_flags = fl;
    end
  endtask

  // Advance one cycle; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; ALU_OP = 4'b0000; rs2_imm_s = 0; w_data_s = 0;
    Reg_Write = 0; IR_Write = 0; PC_Write = 0;
  endtask

  task automatic fetch(input logic [31:0] inst);
    idle();
    inst_data = inst; IR_Write = 1;
    tick();
    IR_Write = 0;
  endtask

  // Observe register idx through the datapath: ADD x0-dest, rs1=idx, rs2=x0.
  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    logic [31:0] inst;
    inst = {12'h000, idx, 3'b000, 5'd0, 7'b0110011};
    fetch(inst);
    tick();
    tick();
    val = alu_f;
  endtask

  task automatic run_imm(input logic [31:0] inst, input logic [3:0] op);
    fetch(inst);
    tick();
    ALU_OP = op; rs2_imm_s = 1;
    tick();
  endtask

  task automatic writeback_f();
    Reg_Write = 1; w_data_s = 0;
    tick();
    idle();
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, ".pc"},  inst_addr, m_pc);
    check({tag, ".op"},  {25'b0, opcode}, {25'b0, m_ir[6:0]});
    check({tag, ".f3"},  {29'b0, funct3}, {29'b0, m_ir[14:12]});
    check({tag, ".f7"},  {25'b0, funct7}, {25'b0, m_ir[31:25]});
    check({tag, ".f"},   alu_f, m_f);
    check({tag, ".flg"}, {28'b0, flags}, {28'b0, m_flags});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc"},  inst_addr, 32'd0);
    check({tag, ".op"},  {25'b0, opcode}, 32'd0);
    check({tag, ".f"},   alu_f, 32'd0);
    check({tag, ".flg"}, {28'b0, flags}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_f = 0; m_flags = 0;
    idle();
    inst_data = 32'd0;
    @(negedge clk);

    // Reset and first fetch.
    rst = 1;
    tick();
    tick();
    check_all_zero("reset");
    idle();
    inst_data = 32'h0050_0093; IR_Write = 1; PC_Write = 1;
    tick();
    check("fetch.pc", inst_addr, 32'd4);
    check("fetch.opcode", {25'b0, opcode}, 32'h13);
    check("fetch.funct3", {29'b0, funct3}, 32'd0);

    // ADDI x1,x0,5 using the already-fetched instruction.
    idle();
    tick();
    ALU_OP = 4'b0000; rs2_imm_s = 1;
    tick();
    check("addi.f", alu_f, 32'd5);
    check("addi.zf", {31'b0, flags[3]}, 32'd0);
    check("addi.flags", {28'b0, flags}, 32'd0);
    writeback_f();
    read_reg(5'd1, v);
    check("addi.x1", v, 32'd5);

    // LUI x2 and LUI to x0.
    fetch(32'h1234_5137);
    Reg_Write = 1; w_data_s = 1;
    tick();
    idle();
    read_reg(5'd2, v);
    check("lui.x2", v, 32'h1234_5000);
    fetch(32'h1234_5037);
    Reg_Write = 1; w_data_s = 1;
    tick();
    idle();
    read_reg(5'd0, v);
    check("lui.x0", v, 32'd0);
    read_reg(5'd2, v);
    check("lui.x2_kept", v, 32'h1234_5000);

    // SUB 0x80000000 - 1: signed overflow, no borrow.
    fetch(32'h8000_02B7);          // LUI x5,0x80000
    Reg_Write = 1; w_data_s = 1;
    tick();
    run_imm(32'h0010_0313, 4'b0000); // ADDI x6,x0,1
    writeback_f();
    fetch(32'h4062_83B3);          // SUB x7,x5,x6
    tick();
    ALU_OP = 4'b1000; rs2_imm_s = 0;
    tick();
    check("sub.f", alu_f, 32'h7FFF_FFFF);
    check("sub.flags", {28'b0, flags}, 32'h1);
    idle();

    // PC wrap from the top of the address space.
    dut.pc_q = 32'hFFFF_FFFC;
    m_pc     = 32'hFFFF_FFFC;
    PC_Write = 1;
    tick();
    check("pc.wrap", inst_addr, 32'd0);
    idle();

    // Reset wins over a write-back of 7 into x3.
    run_imm(32'h0070_0193, 4'b0000); // ADDI x3,x0,7
    check("rstwb.f_pre", alu_f, 32'd7);
    Reg_Write = 1; w_data_s = 0; rst = 1;
    tick();
    check_all_zero("rstwb");
    idle();
    read_reg(5'd3, v);
    check("rstwb.x3", v, 32'd0);

    // Randomized control and instruction streams against the model.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      ALU_OP    = 4'($urandom);
      rs2_imm_s = 1'($urandom);
      w_data_s  = 1'($urandom);
      Reg_Write = 1'($urandom);
      IR_Write  = 1'($urandom);
      PC_Write  = 1'($urandom);
      inst_data = $urandom;
      tick();
      check_vs_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
